// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO and start/data launcher for the UART transmitter
//
// Bytes pushed from the bus side are queued in a circular buffer and handed
// one at a time to the transmitter, which holds tx_data/tx_start stable until
// the byte has been accepted (tx_busy) and completed (tx_done).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    push interface
//   full, empty       FIFO status (count == DEPTH / count == 0)
//   count             entries stored, 0..DEPTH
//   overflow, clr_ovf sticky dropped-push flag and its clear
//   tx_data, tx_start registered byte and start request to the transmitter
//   tx_busy, tx_done  transmitter status / stop-bit-complete pulse
//   idle              FIFO empty and launcher idle
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              idle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              drop;
    logic              pop;
    logic              tx_start_d;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign idle  = empty && (state == IDLE);

    // full is taken from the registered count, so a push to a full FIFO is
    // dropped even when a pop frees a slot in the same cycle.
    assign push = wr_en && !full;
    assign drop = wr_en && full;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tx_start_d = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                // The transmitter may take up to a bit period to notice start,
                // so the request is held until it reports busy.
                if (tx_busy) begin
                    next_state = WAIT;
                end else begin
                    tx_start_d = 1'b1;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= next_state;
            tx_start <= tx_start_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // tx_data only ever changes here, so it stays put through WAIT
            // while the transmitter samples data bits live.
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped push wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a bit-period-4 transmitter model
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       idle;

    int tot = 0;
    int bad = 0;

    uart_tx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    // Transmitter model: bit strobe every 4 cycles, start accepted only on a
    // strobe, data bits read live from tx_data LSB first, then a stop bit.
    logic       stall;
    logic       m_busy;
    logic [1:0] bp_cnt;
    logic [3:0] bit_idx;
    logic [7:0] shreg;
    logic [7:0] held;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (rst) begin
            m_busy  <= 1'b0;
            tx_busy <= 1'b0;
            bp_cnt  <= 2'd0;
            bit_idx <= 4'd0;
        end else begin
            bp_cnt <= bp_cnt + 2'd1;
            if (bp_cnt == 2'd3) begin
                if (!m_busy) begin
                    if (tx_start && !stall) begin
                        m_busy  <= 1'b1;
                        tx_busy <= 1'b1;
                        bit_idx <= 4'd0;
                        held    <= tx_data;
                    end
                end else if (bit_idx == 4'd9) begin
                    m_busy  <= 1'b0;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    rx_q.push_back(shreg);
                end else begin
                    if (bit_idx != 4'd0) begin
                        shreg <= {tx_data[bit_idx[2:0] - 3'd1], shreg[7:1]};
                    end
                    bit_idx <= bit_idx + 4'd1;
                end
            end
        end
    end

    // tx_data must not move while the transmitter is shifting it out.
    always @(negedge clk) begin
        if (!rst && m_busy) begin
            tot++;
            if (tx_data !== held) begin
                bad++;
                $display("FAIL tx_data_stable: got %02h want %02h", tx_data, held);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        tot++;
        if (rx_q.size() < n) begin
            bad++;
            $display("FAIL wait_rx: got %0d bytes want %0d", rx_q.size(), n);
        end
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (tx_done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        tot++;
        if (tx_done !== 1'b1) begin
            bad++;
            $display("FAIL wait_done: got tx_done=%0b want 1 within %0d cycles", tx_done, budget);
        end
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp);
        logic [7:0] got;
        tot++;
        if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got no byte want %02h", name, exp);
        end else begin
            got = rx_q.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL %s: got %02h want %02h", name, got, exp);
            end
        end
    endtask

    task automatic push1(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       clr_ovf;
        int         exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
        logic       exp_start;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // Stalled transmitter: push 0..17 back to back, then clear overflow.
        for (int i = 0; i < 18; i++) begin
            vecs[i].wr_en     = 1'b1;
            vecs[i].wr_data   = 8'(i);
            vecs[i].clr_ovf   = 1'b0;
            vecs[i].exp_count = (i == 0) ? 1 : ((i > 16) ? 16 : i);
            vecs[i].exp_full  = (vecs[i].exp_count == 16);
            vecs[i].exp_empty = 1'b0;
            vecs[i].exp_ovf   = (i == 17);
            vecs[i].exp_start = (i >= 1);
        end
        vecs[18] = '{wr_en: 1'b0, wr_data: 8'h00, clr_ovf: 1'b1, exp_count: 16,
                     exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b0, exp_start: 1'b1};

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_idle", 32'(idle), 1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte, minimum latency.
        push1(8'hA5);
        chk("t1_start_early", 32'(tx_start), 0);
        chk("t1_count_1", 32'(count), 1);
        @(negedge clk);
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_tx_data", 32'(tx_data), 32'h A5);
        chk("t1_count_0", 32'(count), 0);
        wait_rx(1, 300);
        expect_rx("t1_rx", 8'hA5);
        repeat (3) @(negedge clk);
        chk("t1_idle", 32'(idle), 1);
        chk("t1_count_end", 32'(count), 0);

        // Three bytes back to back; restart two cycles after each tx_done.
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        for (int k = 0; k < 2; k++) begin
            wait_done(300);
            @(negedge clk);
            chk("t2_start_gap", 32'(tx_start), 0);
            @(negedge clk);
            chk("t2_restart", 32'(tx_start), 1);
            chk("t2_next_data", 32'(tx_data), (k == 0) ? 32'h22 : 32'h33);
        end
        wait_rx(3, 300);
        expect_rx("t2_rx0", 8'h11);
        expect_rx("t2_rx1", 8'h22);
        expect_rx("t2_rx2", 8'h33);
        repeat (3) @(negedge clk);
        chk("t2_idle", 32'(idle), 1);

        // Fill with transmitter stalled.
        stall = 1'b1;
        for (int i = 0; i < 19; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            clr_ovf = vecs[i].clr_ovf;
            @(negedge clk);
            wr_en   = 1'b0;
            clr_ovf = 1'b0;
            chk($sformatf("t3_count[%0d]", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("t3_full[%0d]", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("t3_empty[%0d]", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("t3_ovf[%0d]", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("t3_start[%0d]", i), 32'(tx_start), 32'(vecs[i].exp_start));
        end
        chk("t3_tx_data", 32'(tx_data), 0);

        // Push into full FIFO on the very cycle of the IDLE->REQ pop.
        stall = 1'b0;
        wait_done(300);
        @(negedge clk);
        chk("t4_full_before", 32'(full), 1);
        push1(8'hEE);
        chk("t4_count", 32'(count), 15);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_full", 32'(full), 0);
        chk("t4_start", 32'(tx_start), 1);
        chk("t4_tx_data", 32'(tx_data), 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 0);
        wait_rx(17, 2000);
        for (int i = 0; i < 17; i++) begin
            expect_rx($sformatf("t4_rx[%0d]", i), 8'(i));
        end
        repeat (3) @(negedge clk);

        // Pointer wrap: 40 bytes as space allows.
        begin
            int sent = 0;
            int c = 0;
            while (sent < 40 && c < 4000) begin
                if (!full) begin
                    wr_en   = 1'b1;
                    wr_data = 8'h80 + 8'(sent);
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
                @(negedge clk);
                c++;
            end
            wr_en = 1'b0;
            chk("t5_sent", 32'(sent), 40);
        end
        wait_rx(40, 3000);
        for (int i = 0; i < 40; i++) begin
            expect_rx($sformatf("t5_rx[%0d]", i), 8'h80 + 8'(i));
        end
        chk("t5_ovf", 32'(overflow), 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a byte.
        push1(8'h77);
        push1(8'h88);
        begin
            int c = 0;
            while (tx_busy !== 1'b1 && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("t6_busy_seen", 32'(tx_busy), 1);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_start", 32'(tx_start), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_idle", 32'(idle), 1);
        rst = 1'b0;
        rx_q.delete();
        @(negedge clk);
        push1(8'h3C);
        wait_rx(1, 300);
        expect_rx("t6_rx", 8'h3C);
        repeat (3) @(negedge clk);
        chk("t6_idle_end", 32'(idle), 1);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
